// File: rtl/cnn_relu_out_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_relu_out_ctrl_if : layer config, beat strobes and write-bus outputs    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cnn_relu_out_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 9,
  parameter int CH_W   = 11
);
  logic                     layer_start;
  logic [DIM_W-1:0]         cfg_out_w;
  logic [DIM_W-1:0]         cfg_out_h;
  logic [CH_W-1:0]          cfg_out_ch;
  logic [ADDR_W-1:0]        cfg_base_addr;
  logic signed [4:0]        cfg_shift;
  logic                     cfg_isNL;
  logic                     cfg_LT;
  logic                     conv_valid;
  logic                     wrt_en;
  logic signed [4:0]        relu_shift;
  logic                     isNL;
  logic                     LT_conv;
  logic                     wr_we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [CH_W-1:0]          cur_ch;
  logic                     busy;
  logic                     layer_done;
  logic                     err_overrun;

  modport master (
    output layer_start, cfg_out_w, cfg_out_h, cfg_out_ch, cfg_base_addr,
           cfg_shift, cfg_isNL, cfg_LT, conv_valid, wrt_en,
    input  relu_shift, isNL, LT_conv, wr_we, wr_addr, cur_ch, busy,
           layer_done, err_overrun
  );

  modport slave (
    input  layer_start, cfg_out_w, cfg_out_h, cfg_out_ch, cfg_base_addr,
           cfg_shift, cfg_isNL, cfg_LT, conv_valid, wrt_en,
    output relu_shift, isNL, LT_conv, wr_we, wr_addr, cur_ch, busy,
           layer_done, err_overrun
  );
endinterface
`default_nettype wire

// File: rtl/cnn_relu_out_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_relu_out_ctrl : layer controller for the 13-lane leaky-ReLU stage      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cnn_relu_out_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DIM_W    = 9,
  parameter int CH_W     = 11,
  parameter int PIPE_LAT = 2
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  cnn_relu_out_ctrl_if.slave  bus
);
  localparam int TOT_W = 2*DIM_W + CH_W;
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [TOT_W-1:0] c_PIPE_LAT = TOT_W'(PIPE_LAT);

  logic [1:0]        r_state;
  logic [DIM_W-1:0]  r_w;
  logic [DIM_W-1:0]  r_h;
  logic [TOT_W-1:0]  r_total;
  logic signed [4:0] r_shift;
  logic              r_isnl;
  logic              r_lt;
  logic [TOT_W-1:0]  r_iss;
  logic [TOT_W-1:0]  r_wrc;
  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_row;
  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  logic              w_run;
  logic              w_iss_ok;
  logic              w_wr_ok;
  logic [TOT_W-1:0]  w_iss_nxt;
  logic [TOT_W-1:0]  w_wrc_nxt;
  logic [TOT_W-1:0]  w_total;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_err_set;

  assign w_run     = (r_state == c_RUN);
  assign w_total   = TOT_W'(bus.cfg_out_w) * TOT_W'(bus.cfg_out_h) * TOT_W'(bus.cfg_out_ch);
  assign w_iss_ok  = bus.conv_valid && (r_iss != r_total);
  // A write is only legal for a beat that was actually issued into the pipe
  assign w_wr_ok   = w_run && bus.wrt_en && (r_wrc < r_iss);
  assign w_iss_nxt = w_iss_ok ? r_iss + TOT_W'(1) : r_iss;
  assign w_wrc_nxt = w_wr_ok  ? r_wrc + TOT_W'(1) : r_wrc;
  assign w_col_last = (r_col == r_w - DIM_W'(1));
  assign w_row_last = (r_row == r_h - DIM_W'(1));

  assign w_err_set = w_run ? ((bus.conv_valid && !w_iss_ok) ||
                              (bus.wrt_en && !w_wr_ok) ||
                              ((w_iss_nxt - w_wrc_nxt) > c_PIPE_LAT))
                           : (bus.conv_valid || bus.wrt_en);

  assign bus.wr_we       = w_wr_ok;
  assign bus.wr_addr     = w_wr_ok ? r_addr : '0;
  assign bus.cur_ch      = w_wr_ok ? r_ch : '0;
  assign bus.busy        = (r_state != c_IDLE);
  assign bus.layer_done  = (r_state == c_DONE);
  assign bus.relu_shift  = r_shift;
  assign bus.isNL        = r_isnl;
  assign bus.LT_conv     = r_lt;
  assign bus.err_overrun = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_w     <= '0;
      r_h     <= '0;
      r_total <= '0;
      r_shift <= '0;
      r_isnl  <= 1'b0;
      r_lt    <= 1'b0;
      r_iss   <= '0;
      r_wrc   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_ch    <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
      case (r_state)
        c_IDLE: begin
          if (bus.layer_start) begin
            r_w     <= bus.cfg_out_w;
            r_h     <= bus.cfg_out_h;
            r_total <= w_total;
            r_shift <= bus.cfg_shift;
            r_isnl  <= bus.cfg_isNL;
            r_lt    <= bus.cfg_LT;
            r_iss   <= '0;
            r_wrc   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_ch    <= '0;
            r_addr  <= bus.cfg_base_addr;
            r_state <= (w_total == '0) ? c_DONE : c_RUN;
          end
        end
        c_RUN: begin
          r_iss <= w_iss_nxt;
          r_wrc <= w_wrc_nxt;
          if (w_wr_ok) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_row <= '0;
                r_ch  <= r_ch + CH_W'(1);
              end else begin
                r_row <= r_row + DIM_W'(1);
              end
            end else begin
              r_col <= r_col + DIM_W'(1);
            end
            if (w_wrc_nxt == r_total) r_state <= c_DONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
